// File: rtl/fetch_unit.sv
// fetch_unit: PC register, preloadable instruction memory and one-stage registered fetch with decode taps.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int IM_DEPTH = 1024,
  parameter int AW = $clog2(IM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          im_we,
  input  logic [AW-1:0] im_waddr,
  input  logic [31:0]   im_wdata,
  output logic [31:0]   pc,
  output logic [31:0]   if_pc,
  output logic [31:0]   if_pc4,
  output logic [31:0]   instr,
  output logic          if_valid,
  output logic [5:0]    op,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    fun,
  output logic [15:0]   imm16,
  output logic [25:0]   imm26,
  output logic          fault
);
  localparam logic [32:0] SPAN = 33'(IM_DEPTH) << 2;
  logic [31:0] mem [IM_DEPTH];
  logic [31:0] off;
  logic [31:0] fetched;
  logic        in_range;
  // A single unsigned offset compare covers both the lower and upper bound.
  assign off      = pc - RESET_PC;
  assign in_range = {1'b0, off} < SPAN;
  assign fetched  = in_range ? mem[off[AW+1:2]] : 32'h0;
  always_ff @(posedge clk)
    if (im_we) mem[im_waddr] <= im_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_pc    <= RESET_PC;
      instr    <= '0;
      if_valid <= 1'b0;
      fault    <= 1'b0;
    end else if (redirect) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      if_valid <= 1'b0;
      if (|redirect_pc[1:0]) fault <= 1'b1;
    end else if (!stall) begin
      pc       <= pc + 32'd4;
      instr    <= fetched;
      if_pc    <= pc;
      if_valid <= 1'b1;
      if (!in_range) fault <= 1'b1;
    end
  assign if_pc4 = if_pc + 32'd4;
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign fun    = instr[5:0];
  assign imm16  = instr[15:0];
  assign imm26  = instr[25:0];
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL provide parameter IM_DEPTH, default 1024, the instruction memory depth in 32-bit words (power of two, at least 2).
REQ-003 SHALL provide parameter AW, default log2(IM_DEPTH), the word-index width.
REQ-004 SHALL have ports, one per line, clock and reset first:
  clk  in  1  single clock; all state updates on the rising edge
  rst_n  in  1  asynchronous, active-low reset
  stall  in  1  hold the PC and the output stage
  redirect  in  1  load redirect_pc (branch/jump target)
  redirect_pc  in  32  target byte address
  im_we  in  1  instruction-memory preload write enable
  im_waddr  in  AW  preload word index
  im_wdata  in  32  preload data
  pc  out  32  current fetch PC
  if_pc  out  32  PC of the registered instruction
  if_pc4  out  32  if_pc+4
  instr  out  32  registered instruction word
  if_valid  out  1  instr/if_pc hold a valid instruction
  op  out  6  instr[31:26]
  rs  out  5  instr[25:21]
  rt  out  5  instr[20:16]
  rd  out  5  instr[15:11]
  shamt  out  5  instr[10:6]
  fun  out  6  instr[5:0]
  imm16  out  16  instr[15:0]
  imm26  out  26  instr[25:0]
  fault  out  1  sticky address-fault flag

Function
REQ-005 SHALL store IM_DEPTH x 32 words, written synchronously when im_we=1, with no reset on contents.
REQ-006 SHALL read the memory combinationally at word index (pc-RESET_PC)[AW+1:2].
REQ-007 SHALL treat pc as in range when RESET_PC <= pc < RESET_PC+4*IM_DEPTH; an out-of-range fetch SHALL deliver 32'h0000_0000 (nop) and set fault.
REQ-008 SHALL, in a normal cycle (stall=0, redirect=0), load pc with pc+4 (mod 2^32), instr with mem[pc], if_pc with pc, and if_valid with 1.
REQ-009 SHALL, when stall=1 and redirect=0, hold pc, instr, if_pc and if_valid unchanged.
REQ-010 SHALL, when redirect=1 (stall ignored), load pc with {redirect_pc[31:2],2'b00} and clear if_valid (flush of the wrong-path fetch); instr and if_pc SHALL be don't-care while if_valid=0.
REQ-011 SHALL set fault when redirect=1 and redirect_pc[1:0]!=0; the aligned address is still loaded.
REQ-012 SHALL keep fault at 1 until reset once it is set.
REQ-013 SHALL derive op, rs, rt, rd, shamt, fun, imm16 and imm26 combinationally from the registered instr, and compute if_pc4 = if_pc+4.
REQ-014 SHALL complete a write and a read of the same word in the same cycle with the old data on the read (read-before-write).
REQ-015 SHALL have latency 1: the instruction at address A is on instr, with if_valid=1, one edge after pc=A in a non-stall, non-redirect cycle.
REQ-016 SHALL hold pc at the wrapped value and continue fetching after pc+4 passes 32'hFFFF_FFFC, with fault per REQ-007.

Reset
REQ-017 SHALL, while rst_n=0, immediately force pc=RESET_PC, if_pc=RESET_PC, instr=0, if_valid=0 and fault=0, independent of clk.
REQ-018 SHALL, when rst_n is asserted mid-stall or mid-redirect, override both, discard the pending operation and leave memory contents intact.
REQ-019 SHALL begin fetching at RESET_PC on the first rising edge after rst_n deasserts.

Verification
REQ-020 SHALL be covered by a reset test: rst_n=0 asynchronously -> pc=0x3000, if_valid=0, fault=0 with no clock edge.
REQ-021 SHALL be covered by a decode test: preload word0=0x014B4820, then release reset -> after 1 edge instr=0x014B4820, op=0, rs=10, rt=11, rd=9, shamt=0, fun=0x20, if_pc=0x3000, if_pc4=0x3004, pc=0x3004.
REQ-022 SHALL be covered by a stall test: stall=1 for 3 cycles at pc=0x3008 -> pc, instr and if_pc unchanged; on release the next edge gives if_pc=0x3008.
REQ-023 SHALL be covered by a redirect test: redirect=1, redirect_pc=0x3040 together with stall=1 -> next edge pc=0x3040, if_valid=0; the following edge gives if_pc=0x3040, if_valid=1.
REQ-024 SHALL be covered by a fault test: redirect_pc=0x3042 -> pc=0x3040 and fault=1; redirect_pc=0x4000 (IM_DEPTH=1024) -> instr=0 with fault=1 held until rst_n=0.
REQ-025 SHALL be covered by a reset-during-operation test: rst_n=0 during a redirect cycle -> pc=0x3000 and if_valid=0, with preloaded words still readable after release.
